// File: rtl/store_buffer.sv
// store_buffer
// Posted-write buffer between the EX/MEM pipeline register and data_mem.
// Stores are queued in a small circular FIFO and written to data_mem on cycles
// where no load needs the single memory port. Loads take priority over the
// drain. A load that hits the word of any pending store stalls until every
// matching entry has drained, which keeps loads coherent without byte merging.
//
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_mem_write      store request from EX/MEM (wins if i_mem_read is also set)
//   i_mem_read       load request from EX/MEM
//   i_bhw            size/sign control, data_mem encoding
//   i_addr, i_data   byte address and store data
//   i_mem_rdata      combinational read data from data_mem
//   o_mem_*          data_mem port (write enable, bhw, address, write data)
//   o_load_data      load result to MEM/WB, zero when no load is granted
//   o_stall          freeze the upstream pipeline
//   o_empty, o_full  registered occupancy flags
//   o_count          number of valid entries
module store_buffer #(
    parameter int B = 32,
    parameter int W = 5,
    parameter int D = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_mem_write,
    input  logic         i_mem_read,
    input  logic [2:0]   i_bhw,
    input  logic [W-1:0] i_addr,
    input  logic [B-1:0] i_data,
    input  logic [B-1:0] i_mem_rdata,
    output logic         o_mem_write,
    output logic [2:0]   o_mem_bhw,
    output logic [W-1:0] o_mem_addr,
    output logic [B-1:0] o_mem_data,
    output logic [B-1:0] o_load_data,
    output logic         o_stall,
    output logic         o_empty,
    output logic         o_full,
    output logic [D:0]   o_count
);

    localparam int DEPTH = 1 << D;
    localparam logic [D:0] COUNT_FULL = (D+1)'(DEPTH);

    logic [2:0]   fifo_bhw  [DEPTH];
    logic [W-1:0] fifo_addr [DEPTH];
    logic [B-1:0] fifo_data [DEPTH];

    logic [D-1:0] head;
    logic [D-1:0] tail;
    logic [D:0]   count;
    logic [D:0]   count_next;
    logic         empty_q;
    logic         full_q;

    logic [DEPTH-1:0] entry_valid;
    logic             word_hit;
    logic             load_req;
    logic             hazard;
    logic             load_go;
    logic             pop;
    logic             push;

    // A simultaneous read and write is a store; the load half is ignored.
    assign load_req = i_mem_read & ~i_mem_write;

    // An entry is valid when its distance from head is below the count.
    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [D-1:0] offset;
            offset = D'(i) - head;
            entry_valid[i] = ({1'b0, offset} < count);
        end
    end

    // Word-granular match against every pending store.
    always_comb begin
        word_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (fifo_addr[i][W-1:2] == i_addr[W-1:2])) begin
                word_hit = 1'b1;
            end
        end
    end

    assign hazard  = load_req & word_hit;
    assign load_go = load_req & ~hazard;

    // The head is not written in a reset cycle so a discarded store never
    // reaches memory.
    assign pop  = ~load_go & (count != '0) & ~i_reset;
    assign push = i_mem_write & ((count != COUNT_FULL) | pop);

    assign o_stall = (i_mem_write & (count == COUNT_FULL) & ~pop) | hazard;

    // Port mux: granted load, else head drain, else idle zeros.
    always_comb begin
        o_mem_write = 1'b0;
        o_mem_bhw   = 3'b000;
        o_mem_addr  = '0;
        o_mem_data  = '0;
        o_load_data = '0;
        if (load_go) begin
            o_mem_bhw   = i_bhw;
            o_mem_addr  = i_addr;
            o_load_data = i_mem_rdata;
        end else if (pop) begin
            o_mem_write = 1'b1;
            o_mem_bhw   = fifo_bhw[head];
            o_mem_addr  = fifo_addr[head];
            o_mem_data  = fifo_data[head];
        end
    end

    assign count_next = count + (D+1)'(push) - (D+1)'(pop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            count   <= count_next;
            empty_q <= (count_next == '0);
            full_q  <= (count_next == COUNT_FULL);
        end
    end

    // Storage needs no reset; validity is tracked by head and count.
    always_ff @(posedge i_clk) begin
        if (push && !i_reset) begin
            fifo_bhw[tail]  <= i_bhw;
            fifo_addr[tail] <= i_addr;
            fifo_data[tail] <= i_data;
        end
    end

    assign o_empty = empty_q;
    assign o_full  = full_q;
    assign o_count = count;

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_mem_write;
    logic        i_mem_read;
    logic [2:0]  i_bhw;
    logic [4:0]  i_addr;
    logic [31:0] i_data;
    logic [31:0] i_mem_rdata;
    logic        o_mem_write;
    logic [2:0]  o_mem_bhw;
    logic [4:0]  o_mem_addr;
    logic [31:0] o_mem_data;
    logic [31:0] o_load_data;
    logic        o_stall;
    logic        o_empty;
    logic        o_full;
    logic [2:0]  o_count;

    store_buffer #(.B(32), .W(5), .D(2)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_mem_write(i_mem_write), .i_mem_read(i_mem_read),
        .i_bhw(i_bhw), .i_addr(i_addr), .i_data(i_data),
        .i_mem_rdata(i_mem_rdata),
        .o_mem_write(o_mem_write), .o_mem_bhw(o_mem_bhw),
        .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
        .o_load_data(o_load_data), .o_stall(o_stall),
        .o_empty(o_empty), .o_full(o_full), .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    // data_mem stand-in: word array, synchronous write, combinational read.
    logic [31:0] dmem [8] = '{default: 32'h0};
    always @(posedge i_clk) begin
        if (o_mem_write) dmem[o_mem_addr[4:2]] <= o_mem_data;
    end
    assign i_mem_rdata = dmem[o_mem_addr[4:2]];

    // Reference model: program-order queue of pending stores plus the
    // memory image those stores should produce.
    typedef struct {
        logic [2:0]  bhw;
        logic [4:0]  addr;
        logic [31:0] data;
    } st_t;
    st_t         q[$];
    logic [31:0] refmem [8] = '{default: 32'h0};
    int          max_size = 0;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One pipeline cycle: drive, predict, check at negedge, advance at posedge.
    task automatic step(input logic wr, input logic rd, input logic [2:0] bhw,
                        input logic [4:0] addr, input logic [31:0] data, input logic rst);
        logic        load, hit, hazard, port_load, drain, push, stall;
        logic [4:0]  ea;
        logic [2:0]  eb;
        logic [31:0] ed, eld;
        st_t         e;
        i_mem_write = wr; i_mem_read = rd; i_bhw = bhw;
        i_addr = addr; i_data = data; i_reset = rst;

        load = rd && !wr;
        hit  = 1'b0;
        foreach (q[k]) if (q[k].addr[4:2] == addr[4:2]) hit = 1'b1;
        hazard    = load && hit;
        port_load = load && !hazard;
        drain     = !port_load && (q.size() > 0) && !rst;
        push      = !rst && wr && ((q.size() < 4) || drain);
        stall     = (wr && q.size() == 4 && !drain) || hazard;
        ea  = port_load ? addr : (drain ? q[0].addr : 5'd0);
        eb  = port_load ? bhw  : (drain ? q[0].bhw  : 3'd0);
        ed  = drain ? q[0].data : 32'd0;
        eld = port_load ? refmem[addr[4:2]] : 32'd0;

        @(negedge i_clk);
        chk("mem_write", 32'(o_mem_write), 32'(drain));
        chk("mem_addr",  32'(o_mem_addr),  32'(ea));
        chk("mem_bhw",   32'(o_mem_bhw),   32'(eb));
        if (!port_load) chk("mem_data", o_mem_data, ed);
        chk("load_data", o_load_data, eld);
        chk("stall",     32'(o_stall), 32'(stall));
        chk("count",     32'(o_count), 32'(q.size()));
        chk("empty",     32'(o_empty), 32'(q.size() == 0));
        chk("full",      32'(o_full),  32'(q.size() == 4));

        @(posedge i_clk);
        if (rst) begin
            q.delete();
        end else begin
            if (drain) begin
                refmem[q[0].addr[4:2]] = q[0].data;
                void'(q.pop_front());
            end
            if (push) begin
                e.bhw = bhw; e.addr = addr; e.data = data;
                q.push_back(e);
            end
        end
        if (q.size() > max_size) max_size = q.size();
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 1'b0);
    endtask

    initial begin
        i_reset = 1'b1; i_mem_write = 1'b0; i_mem_read = 1'b0;
        i_bhw = 3'd0; i_addr = 5'd0; i_data = 32'd0;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;

        @(negedge i_clk);
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full",  32'(o_full),  32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_mem_write", 32'(o_mem_write), 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        @(posedge i_clk); #1;

        // SW 0xDEADBEEF to 4, then it drains.
        step(1'b1, 1'b0, 3'b010, 5'd4, 32'hDEADBEEF, 1'b0);
        chk("sw4_count", 32'(o_count), 32'd1);
        idle();
        chk("sw4_mem", dmem[1], 32'hDEADBEEF);
        idle();
        chk("sw4_empty", 32'(o_empty), 32'd1);

        // SW to 8 then LW 8: one stall cycle, then the load sees the data.
        step(1'b1, 1'b0, 3'b010, 5'd8, 32'hCAFE0008, 1'b0);
        step(1'b0, 1'b1, 3'b010, 5'd8, 32'd0, 1'b0);
        step(1'b0, 1'b1, 3'b010, 5'd8, 32'd0, 1'b0);

        // SW to 4 pending, LW from 12: load wins the port, store drains after.
        step(1'b1, 1'b0, 3'b010, 5'd4, 32'h11110004, 1'b0);
        step(1'b0, 1'b1, 3'b010, 5'd12, 32'd0, 1'b0);
        step(1'b0, 1'b1, 3'b010, 5'd16, 32'd0, 1'b0);
        idle();

        // Store pressure under continuous non-hazard loads, then drain.
        step(1'b1, 1'b0, 3'b010, 5'd20, 32'hA0000020, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'b010, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 3'b010, 5'(4*i), 32'hB0000000 + i, 1'b0);
        repeat (2) idle();

        // Six stores over time so the pointers wrap.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 3'b010, 5'(24 + 4*(i%2)), 32'hC0000000 + i, 1'b0);
            if (i % 2 == 1) idle();
        end
        repeat (2) idle();

        // Reset while a store is pending: it must never be written.
        step(1'b1, 1'b0, 3'b010, 5'd0, 32'hDEAD0000, 1'b0);
        step(1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 1'b1);
        chk("rstmid_count", 32'(o_count), 32'd0);
        chk("rstmid_empty", 32'(o_empty), 32'd1);
        repeat (3) idle();
        chk("rstmid_mem", dmem[0], 32'hB0000000);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            logic rst, wr, rd;
            logic [1:0] w;
            rst = ($urandom_range(0, 99) < 3);
            wr  = !rst && ($urandom_range(0, 99) < 45);
            rd  = !rst && ($urandom_range(0, 99) < 55);
            w   = 2'($urandom_range(0, 3));
            step(wr, rd, 3'($urandom_range(0, 7)), {1'b0, w, 2'b00}, $urandom, rst);
        end
        repeat (3) idle();

        for (int k = 0; k < 8; k++) chk($sformatf("final_mem%0d", k), dmem[k], refmem[k]);
        n_cmp++;
        if (max_size > 4) begin
            n_fail++;
            $display("FAIL max_count observed=%0d required<=4", max_size);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
